// File: rtl/decoder3to8_strobe.sv
// Registered 3-to-8 decoder: queued 3-bit codes become timed one-hot strobes on Y,
// each HOLD cycles long and followed by GAP all-zero cycles.
module decoder3to8_strobe #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       code_valid,
    input  logic [2:0] code,
    output logic       code_ready,
    output logic [7:0] Y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic       GAP_EN    = (GAP > 0) ? 1'b1 : 1'b0;

    function automatic logic [7:0] decode3(input logic [2:0] idx);
        decode3 = 8'b0000_0001 << idx;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic [7:0] y_next_s;
    logic       done_next_s;
    logic       busy_next_s;
    logic       launch_s;
    logic       pop_s;
    logic       push_s;
    logic       can_launch_s;
    logic [2:0] head_s;

    logic [2:0] fifo_mem_r [2];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;
    logic [1:0] count_next_s;

    assign code_ready   = (count_r != 2'd2);
    assign push_s       = code_valid && code_ready;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign can_launch_s = (count_r != 2'd0) && en;

    // FIFO occupancy update; push and pop together at count 1 leave it at 1.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= 3'd0;
            fifo_mem_r[1] <= 3'd0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= code;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    // Next-state and next-output logic; a launch pops the head and loads the hold count.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        y_next_s     = Y;
        done_next_s  = 1'b0;
        launch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (can_launch_s) begin
                    launch_s = 1'b1;
                end else begin
                    y_next_s = 8'd0;
                end
            end
            ST_STROBE: begin
                if (cnt_r != 8'd0) begin
                    cnt_next_s  = cnt_r - 8'd1;
                    done_next_s = (cnt_r == 8'd1);
                end else if (GAP_EN) begin
                    state_next_s = ST_GAP;
                    cnt_next_s   = GAP_LOAD;
                    y_next_s     = 8'd0;
                end else if (can_launch_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                    y_next_s     = 8'd0;
                end
            end
            ST_GAP: begin
                if (cnt_r != 8'd0) begin
                    cnt_next_s = cnt_r - 8'd1;
                end else if (can_launch_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
                y_next_s = 8'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 8'd0;
                y_next_s     = 8'd0;
            end
        endcase
        if (launch_s) begin
            state_next_s = ST_STROBE;
            cnt_next_s   = HOLD_LOAD;
            y_next_s     = decode3(head_s);
            done_next_s  = (HOLD_LOAD == 8'd0);
        end else begin
            cnt_next_s = cnt_next_s;
        end
        pop_s       = launch_s;
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            Y       <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            Y       <= y_next_s;
            busy    <= busy_next_s;
            done    <= done_next_s;
        end
    end

endmodule

// File: tb/tb_decoder3to8_strobe.sv
// Directed bench for decoder3to8_strobe: one instance with HOLD=4/GAP=1, one with HOLD=1/GAP=0.
module tb_decoder3to8_strobe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, valid_a, ready_a, busy_a, done_a;
    logic [2:0] code_a;
    logic [7:0] y_a;
    logic       en_b, valid_b, ready_b, busy_b, done_b;
    logic [2:0] code_b;
    logic [7:0] y_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decoder3to8_strobe #(.HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .code_valid(valid_a), .code(code_a),
        .code_ready(ready_a), .Y(y_a), .busy(busy_a), .done(done_a)
    );

    decoder3to8_strobe #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .code_valid(valid_b), .code(code_b),
        .code_ready(ready_b), .Y(y_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Y must be zero or one-hot on every cycle for both instances.
    always @(negedge clk) begin
        check("onehot_a", {31'd0, $onehot0(y_a)}, 32'd1);
        check("onehot_b", {31'd0, $onehot0(y_b)}, 32'd1);
    end

    initial begin
        logic [7:0] exp_y;
        rst_n = 1'b0;
        en_a = 1'b0; valid_a = 1'b0; code_a = 3'd0;
        en_b = 1'b0; valid_b = 1'b0; code_b = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_y", y_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        rst_n = 1'b1;

        // Single code 5
        en_a = 1'b1; valid_a = 1'b1; code_a = 3'd5;
        step();
        valid_a = 1'b0;
        check("t1_e0_y", y_a, 8'h00);
        check("t1_e0_ready", ready_a, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t1_y", y_a, (i <= 4) ? 8'h20 : 8'h00);
            check("t1_done", done_a, (i == 4) ? 1'b1 : 1'b0);
            check("t1_busy", busy_a, (i <= 5) ? 1'b1 : 1'b0);
        end

        // Streaming 0, 7, 2 with backpressure
        valid_a = 1'b1; code_a = 3'd0;
        step();
        check("t2_ready_e0", ready_a, 1'b1);
        code_a = 3'd7;
        step();
        check("t2_y_e1", y_a, 8'h01);
        check("t2_ready_e1", ready_a, 1'b1);
        code_a = 3'd2;
        step();
        valid_a = 1'b0;
        check("t2_ready_e2", ready_a, 1'b0);
        check("t2_y_e2", y_a, 8'h01);
        for (int i = 3; i <= 16; i++) begin
            step();
            if (i <= 4)                 exp_y = 8'h01;
            else if (i >= 6 && i <= 9)  exp_y = 8'h80;
            else if (i >= 11 && i <= 14) exp_y = 8'h04;
            else                        exp_y = 8'h00;
            check("t2_y", y_a, exp_y);
            check("t2_ready", ready_a, (i <= 5) ? 1'b0 : 1'b1);
        end
        check("t2_busy_end", busy_a, 1'b0);

        // Launch gating
        en_a = 1'b0; valid_a = 1'b1; code_a = 3'd3;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_y_gated", y_a, 8'h00);
            check("t3_busy_gated", busy_a, 1'b0);
        end
        en_a = 1'b1;
        step();
        check("t3_y_launch", y_a, 8'h08);
        repeat (5) step();
        check("t3_busy_end", busy_a, 1'b0);

        // Enable dropped mid-strobe with a second code queued
        valid_a = 1'b1; code_a = 3'd1;
        step();
        code_a = 3'd6;
        step();
        valid_a = 1'b0;
        check("t4_y_c1", y_a, 8'h02);
        step();
        en_a = 1'b0;
        step();
        check("t4_y_c3", y_a, 8'h02);
        step();
        check("t4_y_c4", y_a, 8'h02);
        check("t4_done_c4", done_a, 1'b1);
        step();
        check("t4_y_gap", y_a, 8'h00);
        check("t4_busy_gap", busy_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_y_held", y_a, 8'h00);
            check("t4_busy_held", busy_a, 1'b0);
        end
        check("t4_ready_held", ready_a, 1'b1);
        en_a = 1'b1;
        step();
        check("t4_y_relaunch", y_a, 8'h40);
        repeat (5) step();
        check("t4_busy_end", busy_a, 1'b0);

        // Reset mid-strobe with one code queued
        valid_a = 1'b1; code_a = 3'd2;
        step();
        code_a = 3'd4;
        step();
        valid_a = 1'b0;
        step();
        check("t5_y_pre", y_a, 8'h04);
        check("t5_ready_pre", ready_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_y_async", y_a, 8'h00);
        check("t5_busy_async", busy_a, 1'b0);
        check("t5_ready_async", ready_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_y_after", y_a, 8'h00);
            check("t5_busy_after", busy_a, 1'b0);
        end

        // Zero gap, HOLD=1: codes 0..7 back to back
        en_b = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                valid_b = 1'b1;
                code_b  = 3'(k);
                check("t6_ready", ready_b, 1'b1);
            end else begin
                valid_b = 1'b0;
            end
            step();
            if (k >= 1) begin
                exp_y = 8'd1 << (k - 1);
                check("t6_y", y_b, exp_y);
                check("t6_done", done_b, 1'b1);
            end
        end
        step();
        check("t6_y_end", y_b, 8'h00);
        check("t6_busy_end", busy_b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decoder3to8_strobe.md
# decoder3to8_strobe

Registered 3-to-8 decoder with a valid/ready code input, a 2-entry code queue and timed one-hot output strobes. Each accepted 3-bit code `c` drives output line `Y[c]` high, alone, for exactly `HOLD` cycles, then all lines low for `GAP` cycles. It sits on the drive side of an 8-line select bus, converting binary indices back into one-hot line activity that an 8-to-3 encoder can read.

## Interface
- `HOLD`, default 4: strobe length in cycles, legal range 1..255.
- `GAP`, default 1: all-zero cycles after each strobe, legal range 0..255.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  launch enable; a new strobe starts only while high.
- `code_valid`  in  1  `code` is valid this cycle.
- `code`  in  3  binary index of the line to strobe.
- `code_ready`  out  1  queue can accept; equals "queue not full".
- `Y`  out  8  registered one-hot strobe outputs.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse on the last HOLD cycle of each strobe.

## Operation
- **Accept:** a code is accepted on a rising edge where `code_valid && code_ready`. Accepted codes enter a 2-entry FIFO, oldest first. No code is ever dropped or reordered.
- **FSM states:** IDLE, STROBE, GAP.
  - **IDLE → STROBE:** when the FIFO is non-empty and `en`=1. This pops the head and registers `Y <= 8'b1 << code`.
  - **STROBE:** `Y` is held for `HOLD` cycles by a down-counter. `done`=1 during the final STROBE cycle.
  - **Leaving STROBE:** go to GAP if `GAP`>0, with `Y` <= 0.
  - **Leaving STROBE when `GAP`=0:** go directly to STROBE with the next code if the FIFO is non-empty and `en`=1. Otherwise go to IDLE with `Y` <= 0.
  - **GAP:** `Y`=0 for `GAP` cycles. Then apply the same launch rule as IDLE: start a new STROBE, or fall back to IDLE.
- **Enable:** `en` gates only the launch of a new strobe. A strobe in progress, and its gap, always complete even if `en` falls. The FIFO keeps accepting codes while `en`=0.
- **Output invariant:** `Y` is always zero or exactly one-hot.
- **Simultaneous push and pop:** allowed when the FIFO count is 1; the count stays at 1. When the FIFO is full, `code_ready`=0, so a push can only occur once a pop has freed space on a previous edge.
- **Counter width:** the counter is 8 bits and never wraps. Its load value is `HOLD-1` or `GAP-1`, and it counts down to 0.

## Timing
- **Reset (asynchronous, while `rst_n`=0):** `Y`=0, `busy`=0, `done`=0, FIFO emptied, FSM in IDLE, `code_ready`=1. Reset asserted mid-strobe clears `Y` immediately, without waiting for a clock edge, and discards all queued codes.
- **Latency:** if code `c` is accepted at edge k while the FSM is IDLE and `en`=1, then `Y[c]` rises after edge k+1. There is no FIFO bypass.
- **Strobe duration:** `Y` stays non-zero for exactly `HOLD` cycles. It is then 0 for exactly `GAP` cycles before the next strobe can begin.
- **Outputs:** `busy` and `done` are registered and aligned with `Y`. `code_ready` is combinational from the FIFO count only; it has no combinational path from `code_valid`.
- **Back-to-back throughput:** one strobe every `HOLD+GAP` cycles.

## Test plan
1. **Single code:** reset, `HOLD`=4, `GAP`=1, `en`=1, push code 5 at edge 0 → `Y`=8'h20 for edges 1–4, `done`=1 only in the 4th cycle, then `Y`=0 and `busy`=0 from edge 6.
2. **Streaming with backpressure:** `code_valid` held high with codes 0, 7, 2 in sequence → `code_ready` drops while 2 codes are queued. `Y` sequence is 8'h01, 0, 8'h80, 0, 8'h04, each strobe 4 cycles and each gap 1 cycle. No code is lost or duplicated.
3. **Launch gating:** with `en`=0, push code 3 → `Y`=0 and `busy`=0 indefinitely. Raise `en` at edge n → `Y`=8'h08 after edge n+1.
4. **Enable dropped mid-strobe:** lower `en` during the 2nd STROBE cycle while a second code is queued → the current strobe runs all 4 cycles plus its gap. The queued code does not launch until `en` returns to 1.
5. **Reset mid-strobe:** assert `rst_n`=0 during a strobe with one code queued → `Y`=0 with no clock edge, `code_ready`=1. After release, nothing strobes until a new code is pushed.
6. **Zero gap:** `HOLD`=1, `GAP`=0, push 8 codes 0..7 → `Y` is 01, 02, 04, … 80 on consecutive cycles with no zero cycles between them. `Y` is zero-or-one-hot on every cycle (continuous assertion).
